// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG segment parser: marker codes and parser state encoding.
package jpeg_pkg;

  typedef enum logic [7:0] {
    MK_00   = 8'h00,
    MK_TEM  = 8'h01,
    MK_SOF0 = 8'hC0,
    MK_DHT  = 8'hC4,
    MK_RST0 = 8'hD0,
    MK_SOI  = 8'hD8,
    MK_EOI  = 8'hD9,
    MK_SOS  = 8'hDA,
    MK_DQT  = 8'hDB,
    MK_DRI  = 8'hDD,
    MK_COM  = 8'hFE,
    MK_FF   = 8'hFF
  } marker_e;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_BODY,
    ST_SCAN
  } state_e;

  // RST0..RST7 share the upper five bits of D0.
  function automatic logic is_rst(input logic [7:0] b);
    return (b & 8'hF8) == MK_RST0;
  endfunction

endpackage

// File: rtl/ecs_bit_shifter.sv
// Holds one entropy-coded byte and hands it out MSB first, OUT_W bits per read.
module ecs_bit_shifter #(
  parameter int OUT_W = 1
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             load_i,
  input  logic [7:0]       byte_i,
  input  logic             re_i,
  output logic             bits_valid_o,
  output logic [OUT_W-1:0] bits_o,
  output logic [3:0]       bits_left_next_o
);

  logic [7:0] shift_q, shift_d;
  logic [3:0] left_q, left_d;

  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    if (load_i) begin
      shift_d = byte_i;
      left_d  = 4'd8;
    end else if (re_i && (left_q != 4'd0)) begin
      shift_d = shift_q << OUT_W;
      left_d  = left_q - 4'(OUT_W);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      shift_q <= '0;
      left_q  <= '0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
    end
  end

  assign bits_valid_o     = (left_q != 4'd0);
  assign bits_o           = shift_q[7 -: OUT_W];
  assign bits_left_next_o = left_d;

endmodule

// File: rtl/jpeg_segment_parser.sv
// Walks a JPEG byte stream: decodes marker segments, captures frame/restart
// parameters and delivers de-stuffed entropy-coded scan bits.
module jpeg_segment_parser import jpeg_pkg::*; #(
  parameter int OUT_W = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_sysclk,
  input  logic             i_arstn,
  input  logic             i_byte_en,
  input  logic [7:0]       i_byte,
  output logic             o_ready,
  output logic             o_bits_valid,
  output logic [OUT_W-1:0] o_bits,
  input  logic             i_re,
  output logic [15:0]      o_height,
  output logic [15:0]      o_width,
  output logic [7:0]       o_ncomp,
  output logic [15:0]      o_restart_int,
  output logic             o_soi,
  output logic             o_start,
  output logic             o_rst,
  output logic             o_eoi,
  output logic             o_err,
  output logic [2:0]       o_rst_idx
);

  state_e           state_q, state_d;
  logic             mflag_q, mflag_d;
  logic [7:0]       marker_q, marker_d, len_hi_q, len_hi_d;
  logic [CNT_W-1:0] remain_q, remain_d, offs_q, offs_d, rem_w;
  logic [2:0]       exp_q, exp_d, ridx_q, ridx_d;
  logic             ready_q, ready_d;
  logic             soi_q, soi_d, start_q, start_d, rst_q, rst_d;
  logic             eoi_q, eoi_d, err_q, err_d;
  logic [15:0]      height_q, height_d, width_q, width_d, rint_q, rint_d;
  logic [7:0]       ncomp_q, ncomp_d;
  logic             accept, load;
  logic [7:0]       load_byte;
  logic [3:0]       left_next;
  logic [15:0]      len_w;

  assign accept = i_byte_en && ready_q;
  assign len_w  = {len_hi_q, i_byte};
  assign rem_w  = CNT_W'(len_w - 16'd2);

  always_comb begin
    state_d   = state_q;
    mflag_d   = mflag_q;
    marker_d  = marker_q;
    len_hi_d  = len_hi_q;
    remain_d  = remain_q;
    offs_d    = offs_q;
    exp_d     = exp_q;
    ridx_d    = ridx_q;
    height_d  = height_q;
    width_d   = width_q;
    ncomp_d   = ncomp_q;
    rint_d    = rint_q;
    soi_d     = 1'b0;
    start_d   = 1'b0;
    rst_d     = 1'b0;
    eoi_d     = 1'b0;
    err_d     = 1'b0;
    load      = 1'b0;
    load_byte = i_byte;
    if (accept) begin
      case (state_q)
        ST_HUNT: begin
          if (!mflag_q || (i_byte == MK_FF)) begin
            mflag_d = (i_byte == MK_FF);
          end else begin
            mflag_d = 1'b0;
            if (i_byte == MK_SOI) soi_d = 1'b1;
            else if (i_byte == MK_EOI) eoi_d = 1'b1;
            else if (!is_rst(i_byte) && (i_byte != MK_TEM)) begin
              marker_d = i_byte;
              state_d  = ST_LEN_HI;
            end
          end
        end
        ST_LEN_HI: begin
          len_hi_d = i_byte;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (len_w < 16'd2) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            remain_d = rem_w;
            offs_d   = '0;
            if (rem_w != '0) begin
              state_d = ST_BODY;
            end else if (marker_q == MK_SOS) begin
              state_d = ST_SCAN;
              start_d = 1'b1;
              exp_d   = '0;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_BODY: begin
          remain_d = (remain_q == '0) ? '0 : remain_q - CNT_W'(1);
          offs_d   = (&offs_q) ? offs_q : offs_q + CNT_W'(1);
          if (marker_q == MK_SOF0) begin
            if (offs_q == CNT_W'(1)) height_d[15:8] = i_byte;
            if (offs_q == CNT_W'(2)) height_d[7:0]  = i_byte;
            if (offs_q == CNT_W'(3)) width_d[15:8]  = i_byte;
            if (offs_q == CNT_W'(4)) width_d[7:0]   = i_byte;
            if (offs_q == CNT_W'(5)) ncomp_d        = i_byte;
          end else if (marker_q == MK_DRI) begin
            if (offs_q == '0) begin
              rint_d[15:8] = i_byte;
              exp_d        = '0;
            end
            if (offs_q == CNT_W'(1)) rint_d[7:0] = i_byte;
          end
          if (remain_q <= CNT_W'(1)) begin
            if (marker_q == MK_SOS) begin
              state_d = ST_SCAN;
              start_d = 1'b1;
              exp_d   = '0;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_SCAN: begin
          if (!mflag_q) begin
            if (i_byte == MK_FF) mflag_d = 1'b1;
            else load = 1'b1;
          end else begin
            mflag_d = 1'b0;
            if (i_byte == MK_00) begin
              load      = 1'b1;
              load_byte = MK_FF;
            end else if (is_rst(i_byte)) begin
              rst_d  = 1'b1;
              ridx_d = i_byte[2:0];
              err_d  = (i_byte[2:0] != exp_q);
              exp_d  = i_byte[2:0] + 3'd1;
            end else if (i_byte == MK_EOI) begin
              eoi_d   = 1'b1;
              state_d = ST_HUNT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_HUNT;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    // In SCAN a new byte is only taken once the previous one is fully read out.
    ready_d = (state_d != ST_SCAN) || (left_next == 4'd0);
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q  <= ST_HUNT;
      mflag_q  <= 1'b0;
      marker_q <= '0;
      len_hi_q <= '0;
      remain_q <= '0;
      offs_q   <= '0;
      exp_q    <= '0;
      ridx_q   <= '0;
      ready_q  <= 1'b1;
      soi_q    <= 1'b0;
      start_q  <= 1'b0;
      rst_q    <= 1'b0;
      eoi_q    <= 1'b0;
      err_q    <= 1'b0;
      height_q <= '0;
      width_q  <= '0;
      ncomp_q  <= '0;
      rint_q   <= '0;
    end else begin
      state_q  <= state_d;
      mflag_q  <= mflag_d;
      marker_q <= marker_d;
      len_hi_q <= len_hi_d;
      remain_q <= remain_d;
      offs_q   <= offs_d;
      exp_q    <= exp_d;
      ridx_q   <= ridx_d;
      ready_q  <= ready_d;
      soi_q    <= soi_d;
      start_q  <= start_d;
      rst_q    <= rst_d;
      eoi_q    <= eoi_d;
      err_q    <= err_d;
      height_q <= height_d;
      width_q  <= width_d;
      ncomp_q  <= ncomp_d;
      rint_q   <= rint_d;
    end
  end

  ecs_bit_shifter #(.OUT_W(OUT_W)) u_shift (
    .clk_i            (i_sysclk),
    .arst_ni          (i_arstn),
    .load_i           (load),
    .byte_i           (load_byte),
    .re_i             (i_re),
    .bits_valid_o     (o_bits_valid),
    .bits_o           (o_bits),
    .bits_left_next_o (left_next)
  );

  assign o_ready       = ready_q;
  assign o_height      = height_q;
  assign o_width       = width_q;
  assign o_ncomp       = ncomp_q;
  assign o_restart_int = rint_q;
  assign o_soi         = soi_q;
  assign o_start       = start_q;
  assign o_rst         = rst_q;
  assign o_eoi         = eoi_q;
  assign o_err         = err_q;
  assign o_rst_idx     = ridx_q;

endmodule

// File: tb/tb_jpeg_segment_parser.sv
// Self-checking bench for jpeg_segment_parser (OUT_W=1 and OUT_W=4 instances).
module tb_jpeg_segment_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arstn;
  logic en1, re1, en4, re4;
  logic [7:0] byte1, byte4;
  logic ready1, bv1, ready4, bv4;
  logic [0:0] bits1;
  logic [3:0] bits4;
  logic [15:0] h1, w1, ri1, h4, w4, ri4;
  logic [7:0] nc1, nc4;
  logic soi1, start1, rst1, eoi1, err1, soi4, start4, rst4, eoi4, err4;
  logic [2:0] ridx1, ridx4;

  int n_checks = 0;
  int n_fail = 0;
  int soi_n, start_n, eoi_n, err_n;
  logic [3:0] rstq[$];
  logic bitq[$];
  bit re_rand = 1'b0;

  jpeg_segment_parser #(.OUT_W(1), .CNT_W(16)) dut1 (
    .i_sysclk(clk), .i_arstn(arstn), .i_byte_en(en1), .i_byte(byte1),
    .o_ready(ready1), .o_bits_valid(bv1), .o_bits(bits1), .i_re(re1),
    .o_height(h1), .o_width(w1), .o_ncomp(nc1), .o_restart_int(ri1),
    .o_soi(soi1), .o_start(start1), .o_rst(rst1), .o_eoi(eoi1), .o_err(err1),
    .o_rst_idx(ridx1)
  );

  jpeg_segment_parser #(.OUT_W(4), .CNT_W(16)) dut4 (
    .i_sysclk(clk), .i_arstn(arstn), .i_byte_en(en4), .i_byte(byte4),
    .o_ready(ready4), .o_bits_valid(bv4), .o_bits(bits4), .i_re(re4),
    .o_height(h4), .o_width(w4), .o_ncomp(nc4), .o_restart_int(ri4),
    .o_soi(soi4), .o_start(start4), .o_rst(rst4), .o_eoi(eoi4), .o_err(err4),
    .o_rst_idx(ridx4)
  );

  // Event monitor for dut1, sampled mid-cycle.
  always @(negedge clk) begin
    if (soi1) soi_n++;
    if (start1) start_n++;
    if (eoi1) eoi_n++;
    if (err1) err_n++;
    if (rst1) rstq.push_back({err1, ridx1});
    if (bv1 && re1) bitq.push_back(bits1[0]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (re_rand) re1 = 1'($urandom_range(0, 1));
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    soi_n = 0; start_n = 0; eoi_n = 0; err_n = 0;
    rstq.delete();
    bitq.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    en1 = 1'b1;
    byte1 = b;
    while (!ready1 && guard < 300) begin
      tick();
      guard++;
    end
    if (!ready1) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout byte=%h ready=%b required 1", b, ready1);
    end
    tick();
    en1 = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    int guard;
    guard = 0;
    en4 = 1'b1;
    byte4 = b;
    while (!ready4 && guard < 300) begin
      tick();
      guard++;
    end
    if (!ready4) begin
      n_checks++; n_fail++;
      $display("FAIL send4_timeout byte=%h ready=%b required 1", b, ready4);
    end
    tick();
    en4 = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    en1 = 0; byte1 = 0; re1 = 0; en4 = 0; byte4 = 0; re4 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ready1, bv1, bits1} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl1 got %b required 100", {ready1, bv1, bits1});
    end
    n_checks++;
    if ({soi1, start1, rst1, eoi1, err1, ridx1} !== 8'h00) begin
      n_fail++; $display("FAIL reset_pulses1 got %b required 0", {soi1, start1, rst1, eoi1, err1, ridx1});
    end
    n_checks++;
    if ({h1, w1, nc1, ri1} !== 56'h0) begin
      n_fail++; $display("FAIL reset_regs1 got %h required 0", {h1, w1, nc1, ri1});
    end
    n_checks++;
    if ({ready4, bv4, bits4} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl4 got %b required 100000", {ready4, bv4, bits4});
    end
    arstn = 1'b1;
    settle(2);
  endtask

  task automatic test_sof();
    logic [7:0] s[$];
    clear_mon();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h00, 8'hF0, 8'h01, 8'h40, 8'h03,
          8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
    foreach (s[i]) send(s[i]);
    settle(3);
    n_checks++;
    if (soi_n !== 1) begin n_fail++; $display("FAIL sof_soi count=%0d required 1", soi_n); end
    n_checks++;
    if (h1 !== 16'd240) begin n_fail++; $display("FAIL sof_height got %0d required 240", h1); end
    n_checks++;
    if (w1 !== 16'd320) begin n_fail++; $display("FAIL sof_width got %0d required 320", w1); end
    n_checks++;
    if (nc1 !== 8'd3) begin n_fail++; $display("FAIL sof_ncomp got %0d required 3", nc1); end
    n_checks++;
    if (err_n !== 0) begin n_fail++; $display("FAIL sof_err count=%0d required 0", err_n); end
  endtask

  task automatic test_app_dri();
    logic [7:0] junk[14];
    logic [15:0] h_before;
    clear_mon();
    h_before = h1;
    foreach (junk[i]) junk[i] = 8'($urandom);
    junk[2] = 8'hFF; junk[3] = 8'hD9; junk[7] = 8'hFF; junk[8] = 8'hDA;
    send(8'hFF); send(8'hE0); send(8'h00); send(8'h10);
    foreach (junk[i]) send(junk[i]);
    send(8'hFF); send(8'hDD); send(8'h00); send(8'h04); send(8'h00); send(8'h10);
    settle(3);
    n_checks++;
    if (ri1 !== 16'd16) begin n_fail++; $display("FAIL dri_restart_int got %0d required 16", ri1); end
    n_checks++;
    if (err_n !== 0) begin n_fail++; $display("FAIL app0_err count=%0d required 0", err_n); end
    n_checks++;
    if ({eoi_n, start_n} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL app0_junk_events eoi=%0d start=%0d required 0 0", eoi_n, start_n);
    end
    n_checks++;
    if (h1 !== h_before) begin n_fail++; $display("FAIL app0_height got %0d required %0d", h1, h_before); end
  endtask

  task automatic test_scan();
    logic [23:0] got;
    clear_mon();
    re1 = 1'b1;
    send(8'hFF); send(8'hDA); send(8'h00); send(8'h0C);
    repeat (10) send(8'($urandom));
    settle(2);
    n_checks++;
    if (start_n !== 1) begin n_fail++; $display("FAIL sos_start count=%0d required 1", start_n); end
    send(8'hA5);
    n_checks++;
    if (bv1 !== 1'b1) begin n_fail++; $display("FAIL scan_latency bits_valid=%b required 1", bv1); end
    send(8'hFF); send(8'h00); send(8'h3C); send(8'hFF); send(8'hD9);
    settle(3);
    got = '0;
    foreach (bitq[i]) got = {got[22:0], bitq[i]};
    n_checks++;
    if (bitq.size() !== 24) begin n_fail++; $display("FAIL scan_bitcount got %0d required 24", bitq.size()); end
    n_checks++;
    if (got !== 24'hA5FF3C) begin n_fail++; $display("FAIL scan_bits got %h required a5ff3c", got); end
    n_checks++;
    if ({eoi_n, err_n} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL scan_eoi eoi=%0d err=%0d required 1 0", eoi_n, err_n);
    end
    send(8'hFF); send(8'hD8);
    settle(3);
    n_checks++;
    if (soi_n !== 1) begin n_fail++; $display("FAIL scan_back_to_hunt soi=%0d required 1", soi_n); end
    re1 = 1'b0;
  endtask

  task automatic test_rst();
    logic [31:0] got;
    logic [7:0] s[$];
    clear_mon();
    re1 = 1'b1;
    s = '{8'hFF, 8'hDA, 8'h00, 8'h02, 8'h12, 8'hFF, 8'hD0, 8'h34, 8'hFF, 8'hD1,
          8'h56, 8'hFF, 8'hD3, 8'h78, 8'hFF, 8'hD9};
    foreach (s[i]) send(s[i]);
    settle(3);
    n_checks++;
    if (rstq.size() !== 3) begin
      n_fail++; $display("FAIL rst_count got %0d required 3", rstq.size());
    end else begin
      n_checks++;
      if ({rstq[0], rstq[1], rstq[2]} !== {4'h0, 4'h1, 4'hB}) begin
        n_fail++; $display("FAIL rst_idx_err got %h%h%h required 01b", rstq[0], rstq[1], rstq[2]);
      end
    end
    n_checks++;
    if (err_n !== 1) begin n_fail++; $display("FAIL rst_err count=%0d required 1", err_n); end
    got = '0;
    foreach (bitq[i]) got = {got[30:0], bitq[i]};
    n_checks++;
    if ({bitq.size(), got} !== {32'd32, 32'h12345678}) begin
      n_fail++; $display("FAIL rst_bits got %0d bits %h required 32 bits 12345678", bitq.size(), got);
    end
    re1 = 1'b0;
  endtask

  task automatic test_random_ecs();
    for (int it = 0; it < 6; it++) begin
      logic [15:0] h, w;
      logic [7:0] nc, d;
      logic [7:0] exp_bytes[$];
      logic [3:0] exp_rst[$];
      logic expb[$];
      logic [2:0] e, idx;
      int nd, nerr, mism;
      exp_bytes.delete(); exp_rst.delete(); expb.delete();
      clear_mon();
      re_rand = 1'b1;
      h = 16'($urandom); w = 16'($urandom); nc = 8'($urandom);
      send(8'hFF); send(8'hC0); send(8'h00); send(8'h08); send(8'h08);
      send(h[15:8]); send(h[7:0]); send(w[15:8]); send(w[7:0]); send(nc);
      settle(2);
      n_checks++;
      if ({h1, w1, nc1} !== {h, w, nc}) begin
        n_fail++; $display("FAIL rand_sof got %h required %h", {h1, w1, nc1}, {h, w, nc});
      end
      send(8'hFF); send(8'hDA); send(8'h00); send(8'h08);
      repeat (6) send(8'($urandom));
      e = 3'd0; nerr = 0;
      nd = $urandom_range(3, 10);
      for (int k = 0; k < nd; k++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) d = 8'hFF;
        exp_bytes.push_back(d);
        send(d);
        if (d == 8'hFF) send(8'h00);
        if ($urandom_range(0, 2) == 0) begin
          idx = ($urandom_range(0, 1) == 0) ? e : 3'($urandom);
          exp_rst.push_back({idx != e, idx});
          if (idx != e) nerr++;
          e = idx + 3'd1;
          send(8'hFF);
          send(8'hD0 | {5'd0, idx});
        end
      end
      send(8'hFF); send(8'hD9);
      settle(3);
      foreach (exp_bytes[i]) for (int b = 7; b >= 0; b--) expb.push_back(exp_bytes[i][b]);
      n_checks++;
      if (bitq.size() !== expb.size()) begin
        n_fail++; $display("FAIL rand_bitcount got %0d required %0d", bitq.size(), expb.size());
      end else begin
        mism = 0;
        foreach (expb[i]) if (bitq[i] !== expb[i]) mism++;
        n_checks++;
        if (mism !== 0) begin n_fail++; $display("FAIL rand_bits got %0d wrong bits required 0", mism); end
      end
      n_checks++;
      if (rstq.size() !== exp_rst.size()) begin
        n_fail++; $display("FAIL rand_rstcount got %0d required %0d", rstq.size(), exp_rst.size());
      end else begin
        foreach (exp_rst[i]) begin
          n_checks++;
          if (rstq[i] !== exp_rst[i]) begin
            n_fail++; $display("FAIL rand_rst[%0d] got %h required %h", i, rstq[i], exp_rst[i]);
          end
        end
      end
      n_checks++;
      if ({err_n, eoi_n} !== {nerr, 32'd1}) begin
        n_fail++; $display("FAIL rand_err_eoi got err=%0d eoi=%0d required %0d 1", err_n, eoi_n, nerr);
      end
    end
    re_rand = 1'b0;
    re1 = 1'b0;
  endtask

  task automatic test_out4();
    re4 = 1'b0;
    send4(8'hFF); send4(8'hDA); send4(8'h00); send4(8'h02);
    n_checks++;
    if (start4 !== 1'b1) begin n_fail++; $display("FAIL out4_start got %b required 1", start4); end
    send4(8'hC3);
    n_checks++;
    if ({bv4, bits4, ready4} !== {1'b1, 4'hC, 1'b0}) begin
      n_fail++; $display("FAIL out4_first got v=%b bits=%h rdy=%b required 1 c 0", bv4, bits4, ready4);
    end
    tick();
    n_checks++;
    if ({bv4, bits4, ready4} !== {1'b1, 4'hC, 1'b0}) begin
      n_fail++; $display("FAIL out4_hold got v=%b bits=%h rdy=%b required 1 c 0", bv4, bits4, ready4);
    end
    re4 = 1'b1;
    tick();
    re4 = 1'b0;
    n_checks++;
    if ({bv4, bits4, ready4} !== {1'b1, 4'h3, 1'b0}) begin
      n_fail++; $display("FAIL out4_second got v=%b bits=%h rdy=%b required 1 3 0", bv4, bits4, ready4);
    end
    tick();
    n_checks++;
    if ({bv4, bits4, ready4} !== {1'b1, 4'h3, 1'b0}) begin
      n_fail++; $display("FAIL out4_hold2 got v=%b bits=%h rdy=%b required 1 3 0", bv4, bits4, ready4);
    end
    re4 = 1'b1;
    tick();
    re4 = 1'b0;
    n_checks++;
    if ({bv4, ready4} !== 2'b01) begin
      n_fail++; $display("FAIL out4_drained got v=%b rdy=%b required 0 1", bv4, ready4);
    end
    send4(8'hFF); send4(8'hD9);
    n_checks++;
    if (eoi4 !== 1'b1) begin n_fail++; $display("FAIL out4_eoi got %b required 1", eoi4); end
  endtask

  task automatic test_len_err_reset();
    clear_mon();
    send(8'hFF); send(8'hC4); send(8'h00); send(8'h01);
    n_checks++;
    if (err1 !== 1'b1) begin n_fail++; $display("FAIL len_err_pulse got %b required 1", err1); end
    tick();
    n_checks++;
    if (err1 !== 1'b0) begin n_fail++; $display("FAIL len_err_single got %b required 0", err1); end
    send(8'hFF); send(8'hD8);
    settle(2);
    n_checks++;
    if (soi_n !== 1) begin n_fail++; $display("FAIL len_err_hunt soi=%0d required 1", soi_n); end
    re1 = 1'b0;
    send(8'hFF); send(8'hDA); send(8'h00); send(8'h02);
    send(8'h5A);
    #2;
    arstn = 1'b0;
    #1;
    n_checks++;
    if ({ready1, bv1, bits1} !== 3'b100) begin
      n_fail++; $display("FAIL midscan_reset_ctrl got %b required 100", {ready1, bv1, bits1});
    end
    n_checks++;
    if ({soi1, start1, rst1, eoi1, err1, ridx1} !== 8'h00) begin
      n_fail++; $display("FAIL midscan_reset_pulses got %b required 0", {soi1, start1, rst1, eoi1, err1, ridx1});
    end
    n_checks++;
    if ({h1, w1, nc1, ri1} !== 56'h0) begin
      n_fail++; $display("FAIL midscan_reset_regs got %h required 0", {h1, w1, nc1, ri1});
    end
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    clear_mon();
    re1 = 1'b1;
    send(8'h9A); send(8'hFF); send(8'hD8);
    settle(3);
    n_checks++;
    if ({soi_n, bitq.size()} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL post_reset_hunt soi=%0d bits=%0d required 1 0", soi_n, bitq.size());
    end
    re1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sof();
    test_app_dri();
    test_scan();
    test_rst();
    test_random_ecs();
    test_out4();
    test_len_err_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
